// File: rtl/router_sync_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_sync_n : steers writes and full status to the addressed output FIFO
//                 and times out unread channels with a one-cycle soft reset.
// Revision 1.0
// ---------------------------------------------------------------------------
module router_sync_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 5,
  parameter int TIMEOUT   = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [CNT_W-1:0]     timeout_cfg,
  input  logic                 clr_status,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err,
  output logic [NUM_PORTS-1:0] timeout_status
);

  localparam logic [ADDR_W:0]  NUM_PORTS_EXT = NUM_PORTS[ADDR_W:0];
  localparam logic [CNT_W-1:0] TIMEOUT_DEF   = TIMEOUT[CNT_W-1:0];

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_vld;
  logic                 addr_in_range;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] waiting;
  logic [CNT_W-1:0]     thr;
  logic [CNT_W-1:0]     thr_m1;
  logic [CNT_W-1:0]     cnt [NUM_PORTS];

  assign addr_in_range = ({1'b0, data_in} < NUM_PORTS_EXT);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q   <= '0;
      addr_vld <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= detect_add && !addr_in_range;
      if (detect_add) begin
        addr_q   <= data_in;
        addr_vld <= addr_in_range;
      end
    end
  end

  // One-hot select of the latched address; all-zero while the address is invalid.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_sel
    assign sel[k] = addr_vld && (addr_q == ADDR_W'(k));
  end

  assign vld_out   = ~empty;
  assign write_enb = write_enb_reg ? sel : '0;
  assign fifo_full = |(full & sel);

  assign waiting = ~empty & ~read_enb;
  assign thr     = (timeout_cfg == '0) ? TIMEOUT_DEF : timeout_cfg;
  assign thr_m1  = thr - CNT_W'(1);

  // The counter restarts in the pulse cycle itself, so continuous waiting
  // pulses with a period of exactly thr cycles.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      soft_reset     <= '0;
      timeout_status <= '0;
      for (int k = 0; k < NUM_PORTS; k++) cnt[k] <= '0;
    end else begin
      if (clr_status) timeout_status <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (waiting[k] && (cnt[k] >= thr_m1)) begin
          soft_reset[k]     <= 1'b1;
          cnt[k]            <= '0;
          timeout_status[k] <= 1'b1;
        end else if (waiting[k]) begin
          soft_reset[k] <= 1'b0;
          cnt[k]        <= cnt[k] + CNT_W'(1);
        end else begin
          soft_reset[k] <= 1'b0;
          cnt[k]        <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_sync_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_sync_n : directed self-checking bench for router_sync_n (3 ports).
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_router_sync_n;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] empty;
  logic [2:0] full;
  logic [4:0] timeout_cfg;
  logic       clr_status;
  logic [2:0] vld_out;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] soft_reset;
  logic       addr_err;
  logic [2:0] timeout_status;

  int total = 0;
  int bad   = 0;

  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .CNT_W(5), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .timeout_cfg(timeout_cfg), .clr_status(clr_status), .vld_out(vld_out),
    .write_enb(write_enb), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .addr_err(addr_err), .timeout_status(timeout_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b1;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000; timeout_cfg = 5'd0; clr_status = 1'b0;

    // Reset held with a valid header presented
    tick(2);
    check("rst_soft_reset", soft_reset, 3'b000);
    check("rst_status", timeout_status, 3'b000);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_write_enb", write_enb, 3'b000);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_vld_out", vld_out, 3'b000);
    resetn = 1'b1; detect_add = 1'b0; full = 3'b111;
    #1;
    check("post_rst_write_enb", write_enb, 3'b000);
    check("post_rst_fifo_full", fifo_full, 1'b0);

    // Latch address 2; old (invalid) address used during the detect cycle
    detect_add = 1'b1; data_in = 2'd2; full = 3'b000;
    #1;
    check("detect_cycle_write_enb", write_enb, 3'b000);
    tick(1);
    detect_add = 1'b0;
    #1;
    check("addr2_write_enb", write_enb, 3'b100);
    full = 3'b100; #1;
    check("addr2_full_set", fifo_full, 1'b1);
    full = 3'b011; #1;
    check("addr2_full_other", fifo_full, 1'b0);
    empty = 3'b010; #1;
    check("vld_out_pattern", vld_out, 3'b101);
    empty = 3'b111;

    // Out-of-range address 3
    detect_add = 1'b1; data_in = 2'd3; full = 3'b111;
    tick(1);
    detect_add = 1'b0;
    #1;
    check("addr3_err_pulse", addr_err, 1'b1);
    check("addr3_write_enb", write_enb, 3'b000);
    check("addr3_fifo_full", fifo_full, 1'b0);
    tick(1);
    check("addr3_err_cleared", addr_err, 1'b0);
    write_enb_reg = 1'b0; full = 3'b000;

    // Channel 0 waiting, default threshold 30
    empty = 3'b110;
    tick(29);
    check("t30_before", soft_reset, 3'b000);
    tick(1);
    check("t30_pulse1", soft_reset, 3'b001);
    check("t30_status", timeout_status, 3'b001);
    tick(1);
    check("t30_after1", soft_reset, 3'b000);
    tick(28);
    check("t30_before2", soft_reset, 3'b000);
    tick(1);
    check("t30_pulse2", soft_reset, 3'b001);
    tick(30);
    check("t30_pulse3", soft_reset, 3'b001);
    empty = 3'b111;
    tick(1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check("t30_status_cleared", timeout_status, 3'b000);

    // Read at waiting cycle 29 restarts the count
    empty = 3'b110;
    tick(28);
    read_enb = 3'b001;
    tick(1);
    read_enb = 3'b000;
    tick(1);
    check("read29_no_pulse", soft_reset, 3'b000);
    tick(1);
    check("read29_no_pulse2", soft_reset, 3'b000);
    check("read29_no_status", timeout_status, 3'b000);
    empty = 3'b111;
    tick(1);

    // Threshold 4 on channels 1 and 2 together
    timeout_cfg = 5'd4; empty = 3'b001;
    tick(3);
    check("t4_before", soft_reset, 3'b000);
    tick(1);
    check("t4_pulse1", soft_reset, 3'b110);
    tick(1);
    check("t4_after1", soft_reset, 3'b000);
    tick(3);
    check("t4_pulse2", soft_reset, 3'b110);
    check("t4_status", timeout_status, 3'b110);
    tick(3);
    clr_status = 1'b1;
    tick(1);
    check("t4_clr_pulse_soft", soft_reset, 3'b110);
    check("t4_set_wins", timeout_status, 3'b110);
    tick(1);
    clr_status = 1'b0;
    check("t4_clr_applied", timeout_status, 3'b000);
    empty = 3'b111;
    tick(1);

    // Lower threshold from 20 to 5 at count 10
    timeout_cfg = 5'd20; empty = 3'b110;
    tick(10);
    check("lower_before", soft_reset, 3'b000);
    timeout_cfg = 5'd5;
    tick(1);
    check("lower_fire", soft_reset, 3'b001);
    tick(1);
    check("lower_after", soft_reset, 3'b000);
    tick(4);
    check("lower_next_period", soft_reset, 3'b001);
    empty = 3'b111;
    tick(1);

    // Latch address 1, then threshold 1 and reset mid-run
    detect_add = 1'b1; data_in = 2'd1; write_enb_reg = 1'b1;
    tick(1);
    detect_add = 1'b0;
    #1;
    check("addr1_write_enb", write_enb, 3'b010);
    timeout_cfg = 5'd1; empty = 3'b110;
    tick(1);
    check("t1_pulse1", soft_reset, 3'b001);
    tick(1);
    check("t1_pulse2", soft_reset, 3'b001);
    tick(1);
    check("t1_pulse3", soft_reset, 3'b001);
    resetn = 1'b0;
    tick(1);
    check("t1_reset_soft", soft_reset, 3'b000);
    check("t1_reset_status", timeout_status, 3'b000);
    check("t1_reset_addr", write_enb, 3'b000);
    resetn = 1'b1;
    tick(1);
    check("t1_resume", soft_reset, 3'b001);
    empty = 3'b111; write_enb_reg = 1'b0;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
